// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage control, instruction-memory and IF/ID bundle
interface if_stage_if;
   logic        stall_i;
   logic        flush_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] im_addr_o;
   logic [31:0] im_instr_i;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_pc4_o;
   logic        id_valid_o;
   logic        misalign_o;
   logic [31:0] fetch_cnt_o;

   // fetch stage side
   modport master (
      input  stall_i, flush_i, redirect_i, redirect_pc_i, im_instr_i,
      output im_addr_o, id_instr_o, id_pc_o, id_pc4_o, id_valid_o,
             misalign_o, fetch_cnt_o
   );

   // hazard unit / ID stage / instruction memory side
   modport slave (
      output stall_i, flush_i, redirect_i, redirect_pc_i, im_instr_i,
      input  im_addr_o, id_instr_o, id_pc_o, id_pc4_o, id_valid_o,
             misalign_o, fetch_cnt_o
   );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register and IF/ID pipeline register
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic      clk,
   input logic      rst,
   if_stage_if.master bus
);

   logic [31:0] pc_q;
   logic [31:0] pc4;
   logic [31:0] id_instr_q;
   logic [31:0] id_pc_q;
   logic [31:0] id_pc4_q;
   logic        id_valid_q;
   logic        misalign_q;
   logic [31:0] fetch_cnt_q;

   assign pc4 = pc_q + 32'd4;

   // instruction memory is combinational, so the address is the PC itself
   assign bus.im_addr_o   = pc_q;
   assign bus.id_instr_o  = id_instr_q;
   assign bus.id_pc_o     = id_pc_q;
   assign bus.id_pc4_o    = id_pc4_q;
   assign bus.id_valid_o  = id_valid_q;
   assign bus.misalign_o  = misalign_q;
   assign bus.fetch_cnt_o = fetch_cnt_q;

   // PC update: stall holds, redirect loads the word-aligned target, else PC+4
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else if (bus.stall_i) begin
         misalign_q <= 1'b0;
      end else if (bus.redirect_i) begin
         pc_q       <= {bus.redirect_pc_i[31:2], 2'b00};
         misalign_q <= |bus.redirect_pc_i[1:0];
      end else begin
         pc_q       <= pc4;
         misalign_q <= 1'b0;
      end
   end

   // IF/ID register: stall holds, flush inserts a bubble, else capture the fetched word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_instr_q  <= 32'd0;
         id_pc_q     <= 32'd0;
         id_pc4_q    <= 32'd0;
         id_valid_q  <= 1'b0;
         fetch_cnt_q <= 32'd0;
      end else if (bus.stall_i) begin
         id_valid_q  <= id_valid_q;
      end else if (bus.flush_i) begin
         id_instr_q  <= 32'd0;
         id_pc_q     <= 32'd0;
         id_pc4_q    <= 32'd0;
         id_valid_q  <= 1'b0;
      end else begin
         id_instr_q  <= bus.im_instr_i;
         id_pc_q     <= pc_q;
         id_pc4_q    <= pc4;
         id_valid_q  <= 1'b1;
         fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;
   logic clk;
   logic rst;
   logic rst2;
   int   n_cmp;
   int   n_bad;

   if_stage_if bus ();
   if_stage_if bus2 ();

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk (clk),
      .rst (rst2),
      .bus (bus2.master)
   );

   // instruction-memory model: each word is a recognisable function of its address
   function automatic logic [31:0] iw(input logic [31:0] a);
      return 32'hA500_0000 ^ a;
   endfunction

   assign bus.im_instr_i  = iw(bus.im_addr_o);
   assign bus2.im_instr_i = 32'h1234_5678;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      rst2  = 1'b1;
      bus.stall_i        = 1'b0;
      bus.flush_i        = 1'b0;
      bus.redirect_i     = 1'b0;
      bus.redirect_pc_i  = 32'd0;
      bus2.stall_i       = 1'b0;
      bus2.flush_i       = 1'b0;
      bus2.redirect_i    = 1'b0;
      bus2.redirect_pc_i = 32'd0;
      step();

      // reset state
      check("rst_addr",  bus.im_addr_o,   32'd0);
      check("rst_instr", bus.id_instr_o,  32'd0);
      check("rst_pc",    bus.id_pc_o,     32'd0);
      check("rst_pc4",   bus.id_pc4_o,    32'd0);
      check("rst_valid", {31'd0, bus.id_valid_o}, 32'd0);
      check("rst_mis",   {31'd0, bus.misalign_o}, 32'd0);
      check("rst_cnt",   bus.fetch_cnt_o, 32'd0);
      rst = 1'b0;

      // 1: sequential fetch of three words
      for (int i = 0; i < 3; i++) begin
         step();
         check("seq_addr",  bus.im_addr_o,   32'(4 * (i + 1)));
         check("seq_instr", bus.id_instr_o,  iw(32'(4 * i)));
         check("seq_pc",    bus.id_pc_o,     32'(4 * i));
         check("seq_pc4",   bus.id_pc4_o,    32'(4 * (i + 1)));
         check("seq_valid", {31'd0, bus.id_valid_o}, 32'd1);
         check("seq_cnt",   bus.fetch_cnt_o, 32'(i + 1));
      end

      // 2: stall at pc=8 for two edges
      do_reset();
      step();
      step();
      check("pre_stall_addr", bus.im_addr_o, 32'd8);
      bus.stall_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_addr", bus.im_addr_o,   32'd8);
         check("stall_pc",   bus.id_pc_o,     32'd4);
         check("stall_cnt",  bus.fetch_cnt_o, 32'd2);
      end
      bus.stall_i = 1'b0;
      step();
      check("unstall_pc",   bus.id_pc_o,     32'd8);
      check("unstall_addr", bus.im_addr_o,   32'd12);
      check("unstall_cnt",  bus.fetch_cnt_o, 32'd3);

      // 3: redirect + flush to 0x40 from pc=12
      bus.redirect_i    = 1'b1;
      bus.flush_i       = 1'b1;
      bus.redirect_pc_i = 32'h40;
      step();
      check("rf_addr",  bus.im_addr_o,  32'h40);
      check("rf_valid", {31'd0, bus.id_valid_o}, 32'd0);
      check("rf_instr", bus.id_instr_o, 32'd0);
      check("rf_pc",    bus.id_pc_o,    32'd0);
      check("rf_cnt",   bus.fetch_cnt_o, 32'd3);
      bus.redirect_i = 1'b0;
      bus.flush_i    = 1'b0;
      step();
      check("tgt_pc",    bus.id_pc_o,    32'h40);
      check("tgt_valid", {31'd0, bus.id_valid_o}, 32'd1);
      check("tgt_instr", bus.id_instr_o, iw(32'h40));
      check("tgt_addr",  bus.im_addr_o,  32'h44);
      check("tgt_cnt",   bus.fetch_cnt_o, 32'd4);

      // 4: misaligned target 0x43, delay-slot mode (no flush)
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h43;
      step();
      check("mis_addr",  bus.im_addr_o, 32'h40);
      check("mis_pulse", {31'd0, bus.misalign_o}, 32'd1);
      check("mis_slot",  bus.id_pc_o,   32'h44);
      check("mis_cnt",   bus.fetch_cnt_o, 32'd5);
      bus.redirect_i = 1'b0;
      step();
      check("mis_clear", {31'd0, bus.misalign_o}, 32'd0);
      check("mis_pc",    bus.id_pc_o,   32'h40);
      check("mis_addr2", bus.im_addr_o, 32'h44);

      // 5: stall dominates redirect and flush at pc=0x20
      bus.redirect_i    = 1'b1;
      bus.flush_i       = 1'b1;
      bus.redirect_pc_i = 32'h20;
      step();
      check("go20_addr", bus.im_addr_o, 32'h20);
      bus.stall_i       = 1'b1;
      bus.redirect_pc_i = 32'h80;
      step();
      check("sdom_addr",  bus.im_addr_o,   32'h20);
      check("sdom_valid", {31'd0, bus.id_valid_o}, 32'd0);
      check("sdom_cnt",   bus.fetch_cnt_o, 32'd6);
      check("sdom_mis",   {31'd0, bus.misalign_o}, 32'd0);
      bus.stall_i = 1'b0;
      step();
      check("sdom_tgt",    bus.im_addr_o,  32'h80);
      check("sdom_bubble", {31'd0, bus.id_valid_o}, 32'd0);
      check("sdom_instr",  bus.id_instr_o, 32'd0);
      bus.redirect_i = 1'b0;
      bus.flush_i    = 1'b0;

      // 6a: PC wrap from 32'hFFFF_FFFC
      rst2 = 1'b0;
      check("wrap_rst_addr", bus2.im_addr_o, 32'hFFFF_FFFC);
      step();
      check("wrap_addr",  bus2.im_addr_o,  32'd0);
      check("wrap_pc",    bus2.id_pc_o,    32'hFFFF_FFFC);
      check("wrap_pc4",   bus2.id_pc4_o,   32'd0);
      check("wrap_instr", bus2.id_instr_o, 32'h1234_5678);

      // 6b: asynchronous reset mid-cycle with a redirect pending
      step();
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h80;
      #2;
      rst = 1'b1;
      #1;
      check("arst_addr",  bus.im_addr_o,   32'd0);
      check("arst_instr", bus.id_instr_o,  32'd0);
      check("arst_pc",    bus.id_pc_o,     32'd0);
      check("arst_pc4",   bus.id_pc4_o,    32'd0);
      check("arst_valid", {31'd0, bus.id_valid_o}, 32'd0);
      check("arst_mis",   {31'd0, bus.misalign_o}, 32'd0);
      check("arst_cnt",   bus.fetch_cnt_o, 32'd0);
      bus.redirect_i = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("post_rst_addr", bus.im_addr_o, 32'd4);
      check("post_rst_pc",   bus.id_pc_o,   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
